jk_cmd_sequencer: RTL and testbench

//  Upstream driver for the WIDTH-bit JK flip-flop bank. Accepts bit-masked

---
 rtl/jk_ctrl_pkg.sv | 37 +++
 rtl/jk_cmd_fifo.sv | 60 ++++++
 rtl/jk_cmd_sequencer.sv | 99 +++++++++
 tb/tb_jk_cmd_sequencer.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/jk_ctrl_pkg.sv
// Shared op codes and JK encode/next-state helpers for the JK bank command path.
package jk_ctrl_pkg;

    localparam int unsigned OP_W = 2;

    typedef enum logic [OP_W-1:0] {
        OP_HOLD = 2'b00,
        OP_CLR  = 2'b01,
        OP_SET  = 2'b10,
        OP_TGL  = 2'b11
    } jk_op_e;

    // Map an op to the {j,k} pair it drives on a masked bit.
    function automatic logic [1:0] jk_encode(input jk_op_e op);
        logic [1:0] jk;
        case (op)
            OP_HOLD: jk = 2'b00;
            OP_CLR:  jk = 2'b01;
            OP_SET:  jk = 2'b10;
            OP_TGL:  jk = 2'b11;
            default: jk = 2'b00;
        endcase
        return jk;
    endfunction

    function automatic logic jk_next(input logic j, input logic k, input logic q);
        logic qn;
        case ({j, k})
            2'b00:   qn = q;
            2'b01:   qn = 1'b0;
            2'b10:   qn = 1'b1;
            default: qn = ~q;
        endcase
        return qn;
    endfunction

endpackage

// File: rtl/jk_cmd_fifo.sv
// Synchronous command FIFO with registered occupancy and full/empty flags.
module jk_cmd_fifo #(
    parameter int unsigned DW    = 7,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned AW   = $clog2(DEPTH),
    localparam int unsigned LW   = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] din,
    input  logic          pop,
    output logic [DW-1:0] dout,
    output logic          full,
    output logic          empty,
    output logic [LW-1:0] level
);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;
    logic [LW-1:0] level_nxt;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    always_comb begin
        level_nxt = level;
        if (do_push && !do_pop) begin
            level_nxt = level + LW'(1);
        end else if (!do_push && do_pop) begin
            level_nxt = level - LW'(1);
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            level <= level_nxt;
            full  <= (level_nxt == LW'(DEPTH));
            empty <= (level_nxt == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/jk_cmd_sequencer.sv
// Buffers masked JK commands, issues one per cycle as registered j/k vectors,
// and tracks a shadow copy of the bank to flag q feedback disagreement.
module jk_cmd_sequencer
    import jk_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 5,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned LW   = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_mask,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
    input  logic [WIDTH-1:0] q_fb,
    output logic [WIDTH-1:0] q_exp,
    output logic [LW-1:0]    level,
    input  logic             err_clr,
    output logic             err_sticky
);

    localparam int unsigned CW = OP_W + WIDTH;

    logic [CW-1:0]    head;
    logic             full;
    logic             empty;
    jk_op_e           head_op;
    logic [WIDTH-1:0] head_mask;
    logic [1:0]       jk_pair;
    logic [WIDTH-1:0] j_nxt;
    logic [WIDTH-1:0] k_nxt;
    logic [WIDTH-1:0] q_nxt;
    logic             err_nxt;

    jk_cmd_fifo #(
        .DW    (CW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (cmd_valid),
        .din   ({cmd_op, cmd_mask}),
        .pop   (~empty),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    assign cmd_ready = ~full;
    assign head_op   = jk_op_e'(head[CW-1 -: OP_W]);
    assign head_mask = head[WIDTH-1:0];

    // Issue the head command; unmasked bits and idle cycles drive hold (0,0).
    always_comb begin
        jk_pair = jk_encode(head_op);
        j_nxt   = '0;
        k_nxt   = '0;
        if (!empty) begin
            j_nxt = head_mask & {WIDTH{jk_pair[1]}};
            k_nxt = head_mask & {WIDTH{jk_pair[0]}};
        end
    end

    // Shadow bank advances with the j/k currently presented, like the real bank.
    always_comb begin
        q_nxt = q_exp;
        for (int i = 0; i < WIDTH; i++) begin
            q_nxt[i] = jk_next(j[i], k[i], q_exp[i]);
        end
    end

    always_comb begin
        err_nxt = err_sticky;
        if (q_fb != q_exp) begin
            err_nxt = 1'b1;
        end else if (err_clr) begin
            err_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            j          <= '0;
            k          <= '0;
            q_exp      <= '0;
            err_sticky <= 1'b0;
        end else begin
            j          <= j_nxt;
            k          <= k_nxt;
            q_exp      <= q_nxt;
            err_sticky <= err_nxt;
        end
    end

endmodule

// File: tb/tb_jk_cmd_sequencer.sv
// Directed bench for jk_cmd_sequencer: vector table plus hand-written corner sequences.
module tb_jk_cmd_sequencer;

    localparam int unsigned WIDTH = 5;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned LW    = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [WIDTH-1:0] cmd_mask;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    logic [WIDTH-1:0] q_fb;
    logic [WIDTH-1:0] q_exp;
    logic [LW-1:0]    level;
    logic             err_clr;
    logic             err_sticky;

    logic [WIDTH-1:0] bank_q;
    logic             force_en;
    logic [WIDTH-1:0] force_val;

    int n_cmp  = 0;
    int n_fail = 0;

    jk_cmd_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_mask   (cmd_mask),
        .j          (j),
        .k          (k),
        .q_fb       (q_fb),
        .q_exp      (q_exp),
        .level      (level),
        .err_clr    (err_clr),
        .err_sticky (err_sticky)
    );

    always #5 clk = ~clk;

    // Stand-in for the JK flip-flop bank fed by the DUT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bank_q <= '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                case ({j[i], k[i]})
                    2'b00:   bank_q[i] <= bank_q[i];
                    2'b01:   bank_q[i] <= 1'b0;
                    2'b10:   bank_q[i] <= 1'b1;
                    default: bank_q[i] <= ~bank_q[i];
                endcase
            end
        end
    end

    assign q_fb = force_en ? force_val : bank_q;

    typedef struct {
        logic             v;
        logic [1:0]       op;
        logic [WIDTH-1:0] mask;
        logic [WIDTH-1:0] ej;
        logic [WIDTH-1:0] ek;
        logic [WIDTH-1:0] eq;
        logic [LW-1:0]    elv;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [WIDTH-1:0] ej, input logic [WIDTH-1:0] ek,
                           input logic [WIDTH-1:0] eq, input logic [LW-1:0] elv);
        chk({tag, ".j"}, 32'(j), 32'(ej));
        chk({tag, ".k"}, 32'(k), 32'(ek));
        chk({tag, ".q_exp"}, 32'(q_exp), 32'(eq));
        chk({tag, ".level"}, 32'(level), 32'(elv));
        chk({tag, ".ready"}, 32'(cmd_ready), 32'd1);
        chk({tag, ".err"}, 32'(err_sticky), 32'd0);
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        #3 rst = 1'b0;
    endtask

    initial begin
        logic [1:0]       c_op  [5];
        logic [WIDTH-1:0] c_msk [5];
        logic [WIDTH-1:0] e4j   [7];
        logic [WIDTH-1:0] e4k   [7];
        logic [WIDTH-1:0] e4q   [7];
        logic [LW-1:0]    e4l   [7];

        tbl[0]  = '{1'b1, 2'b10, 5'b10101, 5'b00000, 5'b00000, 5'b00000, 3'd1};
        tbl[1]  = '{1'b0, 2'b00, 5'b00000, 5'b10101, 5'b00000, 5'b00000, 3'd0};
        tbl[2]  = '{1'b0, 2'b00, 5'b00000, 5'b00000, 5'b00000, 5'b10101, 3'd0};
        tbl[3]  = '{1'b1, 2'b01, 5'b00001, 5'b00000, 5'b00000, 5'b10101, 3'd1};
        tbl[4]  = '{1'b1, 2'b11, 5'b11111, 5'b00000, 5'b00001, 5'b10101, 3'd1};
        tbl[5]  = '{1'b0, 2'b00, 5'b00000, 5'b11111, 5'b11111, 5'b10100, 3'd0};
        tbl[6]  = '{1'b0, 2'b00, 5'b00000, 5'b00000, 5'b00000, 5'b01011, 3'd0};
        tbl[7]  = '{1'b1, 2'b00, 5'b11111, 5'b00000, 5'b00000, 5'b01011, 3'd1};
        tbl[8]  = '{1'b0, 2'b00, 5'b00000, 5'b00000, 5'b00000, 5'b01011, 3'd0};
        tbl[9]  = '{1'b1, 2'b11, 5'b10000, 5'b00000, 5'b00000, 5'b01011, 3'd1};
        tbl[10] = '{1'b0, 2'b00, 5'b00000, 5'b10000, 5'b10000, 5'b01011, 3'd0};
        tbl[11] = '{1'b0, 2'b00, 5'b00000, 5'b00000, 5'b00000, 5'b11011, 3'd0};

        c_op  = '{2'b10, 2'b10, 2'b01, 2'b11, 2'b10};
        c_msk = '{5'b00001, 5'b00010, 5'b00001, 5'b00110, 5'b10000};
        e4j   = '{5'b00000, 5'b00001, 5'b00010, 5'b00000, 5'b00110, 5'b10000, 5'b00000};
        e4k   = '{5'b00000, 5'b00000, 5'b00000, 5'b00001, 5'b00110, 5'b00000, 5'b00000};
        e4q   = '{5'b00000, 5'b00000, 5'b00001, 5'b00011, 5'b00010, 5'b00100, 5'b10100};
        e4l   = '{3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd0, 3'd0};

        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_mask  = '0;
        err_clr   = 1'b0;
        force_en  = 1'b0;
        force_val = '0;
        #12 rst = 1'b0;

        // Reset state
        tick();
        chk_out("reset", 5'b00000, 5'b00000, 5'b00000, 3'd0);

        // Table: single SET, back-to-back CLR/TGL, HOLD, partial-mask TGL
        for (int r = 0; r < 12; r++) begin
            cmd_valid = tbl[r].v;
            cmd_op    = tbl[r].op;
            cmd_mask  = tbl[r].mask;
            tick();
            chk_out($sformatf("row%0d", r), tbl[r].ej, tbl[r].ek, tbl[r].eq, tbl[r].elv);
        end

        // Five consecutive pushes with the pop path active: issue order follows push order
        do_reset();
        for (int n = 0; n < 7; n++) begin
            cmd_valid = (n < 5);
            cmd_op    = (n < 5) ? c_op[n] : 2'b00;
            cmd_mask  = (n < 5) ? c_msk[n] : 5'b00000;
            tick();
            chk_out($sformatf("stream%0d", n), e4j[n], e4k[n], e4q[n], e4l[n]);
        end

        // Sticky error: set by mismatch, mismatch beats err_clr, cleared once q agrees
        do_reset();
        force_en  = 1'b1;
        force_val = 5'b00001;
        tick();
        chk("err_set", 32'(err_sticky), 32'd1);
        err_clr = 1'b1;
        tick();
        chk("err_clr_vs_mismatch", 32'(err_sticky), 32'd1);
        force_en = 1'b0;
        err_clr  = 1'b0;
        tick();
        chk("err_hold", 32'(err_sticky), 32'd1);
        err_clr = 1'b1;
        tick();
        chk("err_cleared", 32'(err_sticky), 32'd0);
        err_clr = 1'b0;
        tick();
        chk("err_stays_clear", 32'(err_sticky), 32'd0);

        // Async reset with a command queued and a nonzero shadow state
        do_reset();
        cmd_valid = 1'b1; cmd_op = 2'b10; cmd_mask = 5'b11111;
        tick();
        cmd_op = 2'b10; cmd_mask = 5'b01010;
        tick();
        cmd_op = 2'b11; cmd_mask = 5'b00011;
        tick();
        chk_out("pre_rst", 5'b01010, 5'b00000, 5'b11111, 3'd1);
        cmd_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("async_rst.level", 32'(level), 32'd0);
        chk("async_rst.j", 32'(j), 32'd0);
        chk("async_rst.k", 32'(k), 32'd0);
        chk("async_rst.q_exp", 32'(q_exp), 32'd0);
        chk("async_rst.ready", 32'(cmd_ready), 32'd1);
        #3 rst = 1'b0;
        for (int n = 0; n < 3; n++) begin
            tick();
            chk_out($sformatf("post_rst%0d", n), 5'b00000, 5'b00000, 5'b00000, 3'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
